// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges between tick strobes and hands each
// completed count downstream over a valid/ack handshake. Define FREQ_METER_SYNC_EN for asynchronous sig_in.
module freq_meter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          sig_in,
  input  logic          out_ack,
  output logic [CW-1:0] count,
  output logic          out_valid,
  output logic          ovf,
  output logic          overrun
);

  typedef enum logic {ARM, RUN} state_e;

  localparam logic [CW-1:0] ACC_MAX = '1;

  // Handshake: count/ovf are meaningful while out_valid=1; out_ack consumes them when
  // out_valid=1; a close while still valid replaces the data and flags overrun.
  state_e        state_q, state_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          acc_ovf_q, acc_ovf_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;
  logic          overrun_q, overrun_d;
  logic          close;
  logic          rise;

`ifdef FREQ_METER_SYNC_EN
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
`else
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) s3_q <= 1'b0;
    else     s3_q <= sig_in;
  end

  assign rise = sig_in & ~s3_q;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    overrun_d   = overrun_q;
    close       = 1'b0;
    case (state_q)
      ARM: begin
        if (tick) begin
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          // A rise coincident with the tick is folded into the closing window.
          close = 1'b1;
          if (rise && acc_q == ACC_MAX) begin
            count_d = ACC_MAX;
            ovf_d   = 1'b1;
          end else begin
            count_d = acc_q + CW'(rise);
            ovf_d   = acc_ovf_q;
          end
          acc_d       = '0;
          acc_ovf_d   = 1'b0;
          out_valid_d = 1'b1;
          if (out_valid_q) overrun_d = ~out_ack;
        end else if (rise) begin
          if (acc_q == ACC_MAX) acc_ovf_d = 1'b1;
          else                  acc_d     = acc_q + 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
    if (!close && out_ack && out_valid_q) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARM;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      overrun_q   <= overrun_d;
    end
  end

  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign overrun   = overrun_q;

endmodule
